// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
// One operand pair is taken over a valid/ready handshake. A single one-bit
// full-adder slice then runs LSB-first for WIDTH cycles, with the carry held
// in a register between cycles. Sum, carry-out and signed overflow are
// returned over a second valid/ready handshake. The result registers keep
// the last completed result until the next one is ready.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic             accept_s, last_s, fs_s, fc_s;
  logic [WIDTH-1:0] s_next_s;

  // Sum bit of a one-bit full adder.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry bit of a one-bit full adder (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign accept_s = start_valid_i & (state_q == IDLE);
  assign last_s   = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign fs_s     = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
  assign fc_s     = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
  assign s_next_s = {fs_s, s_sh_q[WIDTH-1:1]};

  // State register; a low reset forces IDLE, which also aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, then WIDTH slice cycles, then hold the result until it is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
        else             state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the state register only.
  always_comb begin
    start_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b0;
    case (state_q)
      IDLE: start_ready_o = 1'b1;
      RUN:  busy_o        = 1'b1;
      DONE: begin
        res_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: begin
        start_ready_o = 1'b0;
        res_valid_o   = 1'b0;
        busy_o        = 1'b0;
      end
    endcase
  end

  // Datapath: load operands at accept, shift one bit per RUN cycle, and
  // capture the result on the last slice cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1: the operand is inverted and the carry preset.
      a_sh_q  <= a_i;
      b_sh_q  <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i ? 1'b1 : cin_i;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
      s_sh_q  <= s_next_s;
      carry_q <= fc_s;
      if (last_s) begin
        // carry_q still holds the carry into the MSB here.
        sum_q  <= s_next_s;
        cout_q <= fc_s;
        ovf_q  <= carry_q ^ fc_s;
        cnt_q  <= cnt_q;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8) with hand-computed expected results.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       res_valid, res_ready;
  logic [7:0] sum;
  logic       cout, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready),
    .a_i           (a),
    .b_i           (b),
    .cin_i         (cin),
    .sub_i         (sub),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .sum_o         (sum),
    .cout_o        (cout),
    .ovf_o         (ovf),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one operation: check the latency and the result, optionally hold
  // backpressure, optionally scramble the inputs during RUN, then take the result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                        input logic tsub, input logic [7:0] es, input logic ec,
                        input logic eo, input int hold, input bit scramble);
    int n;
    @(negedge clk);
    check_val("start_ready_idle", 32'(start_ready), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check_val("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      if (scramble && n < 6) begin
        a           = 8'($urandom_range(255));
        b           = 8'($urandom_range(255));
        sub         = 1'($urandom_range(1));
        cin         = 1'($urandom_range(1));
        start_valid = (n % 2 == 0) ? 1'b1 : 1'b0;
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check_val("latency", 32'(n), 32'd8);
    check_val("sum", 32'(sum), 32'(es));
    check_val("cout", 32'(cout), 32'(ec));
    check_val("ovf", 32'(ovf), 32'(eo));
    check_val("start_ready_done", 32'(start_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("bp_res_valid", 32'(res_valid), 32'd1);
      check_val("bp_sum", 32'(sum), 32'(es));
      check_val("bp_flags", 32'({cout, ovf}), 32'({ec, eo}));
      check_val("bp_start_ready", 32'(start_ready), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val("idle_res_valid", 32'(res_valid), 32'd0);
    check_val("idle_start_ready", 32'(start_ready), 32'd1);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_sum_hold", 32'(sum), 32'(es));
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_start_ready", 32'(start_ready), 32'd1);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_flags", 32'({cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Additions
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op(8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    // Subtractions; cIn=1 must have no effect
    run_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    // Backpressure for 5 cycles
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5, 1'b0);
    // Input isolation: inputs and start_valid toggle during RUN
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b1);

    // Reset mid-RUN at cnt=3; sum currently holds 0x7F
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_res_valid", 32'(res_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_sum", 32'(sum), 32'd0);
    check_val("midrst_flags", 32'({cout, ovf}), 32'd0);
    check_val("midrst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
